shift_sequencer: RTL and testbench

- Control FSM that runs one multi-cycle shift instruction on the SRC datapath.
- Loads the shift count from the bus into shift_control (ld), then drives decr and the shift-register enable in lockstep until shift_control reports n (count == 0). Finally it gates the result onto the bus and pulses done.
- Sits between the main control unit (start/op handshake) and the shift_control counter plus the shift register.

---
 rtl/shift_sequencer_pkg.sv | 22 ++
 rtl/shift_sequencer_if.sv | 35 +++
 rtl/shift_sequencer.sv | 122 ++++++++++++
 tb/tb_shift_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared types and default sizes for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SHR  = 2'd0,
    SHRA = 2'd1,
    SHL  = 2'd2,
    SHC  = 2'd3
  } shift_op_t;

  localparam int DEFAULT_CNT_W   = 5;
  localparam int DEFAULT_TIMEOUT = 32;

endpackage

// File: rtl/shift_sequencer_if.sv
// Handshake and datapath-control bundle between the control unit,
// the shift_control counter, the shift register and the sequencer.
interface shift_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) ();

  logic             start;
  shift_op_t        op;
  logic             abort;
  logic             n;
  logic             ld;
  logic             decr;
  logic             shift_en;
  shift_op_t        shift_op;
  logic             c_out;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W:0]   shifted;

  // Control-unit side (also supplies n from the shift_control counter).
  modport master (
    output start, op, abort, n,
    input  ld, decr, shift_en, shift_op, c_out, busy, done, err, shifted
  );

  // Sequencer side.
  modport slave (
    input  start, op, abort, n,
    output ld, decr, shift_en, shift_op, c_out, busy, done, err, shifted
  );

endinterface

// File: rtl/shift_sequencer.sv
// Control FSM for one multi-cycle shift instruction: load the count into
// shift_control, shift until it reports zero, gate the result onto the bus,
// then pulse done. A watchdog aborts a SHIFT phase that never sees n.
// TIMEOUT must be at least 2**CNT_W so the largest legal count never trips it.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  shift_sequencer_if.slave   bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT);

  state_t          state;
  shift_op_t       op_q;
  logic            ld_q;
  logic            c_out_q;
  logic            done_q;
  logic            busy_q;
  logic            err_q;
  logic [CNT_W:0]  shifted_q;
  logic [WD_W-1:0] wd_cnt;
  logic            shift_fire;

  // A shift happens in SHIFT while the count is nonzero; an abort in the
  // same cycle suppresses it so the shift register and counter stay in step
  // with the reported shift total. n feeds straight through, no register.
  assign shift_fire = (state == SHIFT) && !bus.n && !bus.abort;

  assign bus.shift_en = shift_fire;
  assign bus.decr     = shift_fire;
  assign bus.ld       = ld_q;
  assign bus.c_out    = c_out_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.err      = err_q;
  assign bus.shift_op = op_q;
  assign bus.shifted  = shifted_q;

  // Sequencer FSM; ld/c_out/done/busy are registered alongside the state
  // so they are pure functions of the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      op_q      <= SHR;
      ld_q      <= 1'b0;
      c_out_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      shifted_q <= '0;
      wd_cnt    <= '0;
    end else begin
      ld_q    <= 1'b0;
      c_out_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state     <= LOAD;
            op_q      <= bus.op;
            shifted_q <= '0;
            err_q     <= 1'b0;
            wd_cnt    <= '0;
            ld_q      <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (bus.n) begin
            state   <= WRITE;
            c_out_q <= 1'b1;
          end else begin
            shifted_q <= shifted_q + 1'b1;
            if (wd_cnt == WD_LAST) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              err_q  <= 1'b1;
            end else if (wd_cnt != WD_SAT) begin
              wd_cnt <= wd_cnt + 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a behavioural shift_control counter shares a
// tri bus with the sequencer; completions are scoreboarded by done pulse.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int CNT_W   = 5;
  localparam int TIMEOUT = 32;

  logic clk_tb = 1'b0;
  logic rst    = 1'b0;

  always #5 clk_tb = ~clk_tb;

  shift_sequencer_if #(.CNT_W(CNT_W)) sif ();

  shift_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk_tb),
    .rst (rst),
    .bus (sif.slave)
  );

  tri   [CNT_W-1:0] sys_bus;
  logic [CNT_W-1:0] bus_val;
  logic [CNT_W-1:0] cnt;
  logic             force_n_low;

  // Upstream drives the count onto the bus while the sequencer loads it.
  assign sys_bus = sif.ld ? bus_val : 'z;
  assign sif.n   = force_n_low ? 1'b0 : (cnt == '0);

  // Behavioural shift_control counter.
  always @(posedge clk_tb or negedge rst) begin
    if (!rst)          cnt <= '0;
    else if (sif.ld)   cnt <= sys_bus;
    else if (sif.decr) cnt <= cnt - 1'b1;
  end

  int cyc = 0;
  always @(posedge clk_tb) cyc <= cyc + 1;

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    shift_op_t op;
    int        shifted;
    int        done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pop an expectation on every done pulse and compare the completion.
  always @(negedge clk_tb) begin
    if (rst && sif.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_op", sif.shift_op, mon_e.op);
        check("done_shifted", sif.shifted, mon_e.shifted);
        check("done_cycle", cyc, mon_e.done_cyc);
        check("done_err", sif.err, 32'd0);
      end
    end
  end

  // The counter must never be decremented once it reads zero.
  always @(negedge clk_tb) begin
    if (rst && sif.busy && sif.n) check("decr_while_n", sif.decr, 32'd0);
  end

  // Start one operation from a negedge and check every cycle through DONE.
  task automatic run_op(input shift_op_t o, input int k, input int restart_at);
    int  base;
    logic exp_sh;
    sif.op      = o;
    bus_val     = k[CNT_W-1:0];
    sif.start   = 1'b1;
    base        = cyc;
    sb.push_back('{o, k, base + k + 4});
    for (int c = 1; c <= k + 4; c++) begin
      @(negedge clk_tb);
      sif.start = (c == restart_at);
      exp_sh = (c >= 2) && (c <= k + 1);
      check("ld", sif.ld, c == 1);
      check("shift_en", sif.shift_en, exp_sh);
      check("decr", sif.decr, exp_sh);
      check("c_out", sif.c_out, c == k + 3);
      check("done", sif.done, c == k + 4);
      check("busy", sif.busy, 32'd1);
      check("shift_op", sif.shift_op, o);
      if (c == 1) check("err_cleared", sif.err, 32'd0);
    end
    @(negedge clk_tb);
    sif.start = 1'b0;
    check("idle_busy", sif.busy, 32'd0);
    check("idle_shifted", sif.shifted, k);
  endtask

  initial begin
    sif.start   = 1'b0;
    sif.op      = SHR;
    sif.abort   = 1'b0;
    force_n_low = 1'b0;
    bus_val     = '0;

    // Reset state
    #12;
    check("rst_busy", sif.busy, 32'd0);
    check("rst_ld", sif.ld, 32'd0);
    check("rst_done", sif.done, 32'd0);
    check("rst_err", sif.err, 32'd0);
    check("rst_shifted", sif.shifted, 32'd0);
    check("rst_shift_op", sif.shift_op, 32'd0);
    @(negedge clk_tb);
    rst = 1'b1;
    @(negedge clk_tb);
    check("idle_after_rst", sif.busy, 32'd0);

    // Normal operations, including zero and maximum counts
    run_op(SHL, 5, 0);
    run_op(SHR, 0, 0);
    run_op(SHRA, 31, 0);
    // Start re-asserted during SHIFT must be ignored
    run_op(SHC, 6, 4);

    // Abort in the 4th SHIFT cycle
    sif.op    = SHL;
    bus_val   = 5'd10;
    sif.start = 1'b1;
    @(negedge clk_tb);
    sif.start = 1'b0;
    check("abort_ld", sif.ld, 32'd1);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk_tb);
      check("abort_pre_shift", sif.shift_en, 32'd1);
    end
    @(negedge clk_tb);
    sif.abort = 1'b1;
    #1;
    check("abort_shift_en", sif.shift_en, 32'd0);
    check("abort_busy_hold", sif.busy, 32'd1);
    @(negedge clk_tb);
    sif.abort = 1'b0;
    check("abort_busy", sif.busy, 32'd0);
    check("abort_shifted", sif.shifted, 32'd3);
    check("abort_c_out", sif.c_out, 32'd0);
    check("abort_done", sif.done, 32'd0);
    check("abort_op_held", sif.shift_op, SHL);
    repeat (3) begin
      @(negedge clk_tb);
      check("abort_no_done", sif.done, 32'd0);
    end
    run_op(SHR, 2, 0);

    // Asynchronous reset mid-SHIFT with start held
    sif.op    = SHC;
    bus_val   = 5'd10;
    sif.start = 1'b1;
    repeat (3) @(negedge clk_tb);
    check("pre_rst_shift_en", sif.shift_en, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_shift_en", sif.shift_en, 32'd0);
    check("arst_decr", sif.decr, 32'd0);
    check("arst_busy", sif.busy, 32'd0);
    check("arst_shifted", sif.shifted, 32'd0);
    check("arst_shift_op", sif.shift_op, 32'd0);
    check("arst_c_out", sif.c_out, 32'd0);
    repeat (2) begin
      @(negedge clk_tb);
      check("arst_held_busy", sif.busy, 32'd0);
    end
    rst = 1'b1;
    run_op(SHL, 3, 0);

    // Watchdog: n never arrives
    force_n_low = 1'b1;
    sif.op      = SHRA;
    bus_val     = 5'd7;
    sif.start   = 1'b1;
    @(negedge clk_tb);
    sif.start = 1'b0;
    check("wd_ld", sif.ld, 32'd1);
    for (int c = 2; c <= TIMEOUT + 1; c++) begin
      @(negedge clk_tb);
      check("wd_shift_en", sif.shift_en, 32'd1);
    end
    @(negedge clk_tb);
    check("wd_err", sif.err, 32'd1);
    check("wd_busy", sif.busy, 32'd0);
    check("wd_shifted", sif.shifted, TIMEOUT);
    check("wd_shift_en_off", sif.shift_en, 32'd0);
    force_n_low = 1'b0;
    @(negedge clk_tb);
    check("wd_err_sticky", sif.err, 32'd1);
    run_op(SHL, 1, 0);

    // Start together with abort is ignored
    sif.start = 1'b1;
    sif.abort = 1'b1;
    @(negedge clk_tb);
    sif.start = 1'b0;
    sif.abort = 1'b0;
    check("start_abort_busy", sif.busy, 32'd0);
    check("start_abort_ld", sif.ld, 32'd0);

    @(negedge clk_tb);
    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
